hilo_muldiv_ctrl: RTL and testbench
===================================

// Module: hilo_muldiv_ctrl
// PURPOSE
//  Multi-cycle sequencer owning the HI/LO register pair. Replaces the single-cycle
//  combinational multiply in the ALU with an iterative MULT/MULTU/DIV/DIVU engine:
//  one partial step per clock, start/busy/done handshake to the pipeline stall logic.
//  Also services MTHI/MTLO writes. HI/LO outputs feed the MFHI/MFLO forwarding path.
// PARAMETERS
//  XLEN   32  operand / HI / LO width
//  CNT_W  6   iteration counter width (must hold XLEN)
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     asynchronous, active-high reset
//  start        in   1     launch op; sampled only in IDLE
//  op           in   2     00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  a            in   XLEN  multiplicand / dividend (rs)
//  b            in   XLEN  multiplier / divisor (rt)
//  flush        in   1     synchronous abort (exception / branch squash)
//  hi_we        in   1     MTHI write strobe
//  lo_we        in   1     MTLO write strobe
//  wdata        in   XLEN  MTHI/MTLO data
//  busy         out  1     engine occupied; pipeline stalls MFHI/MFLO/new op
//  done         out  1     one-cycle pulse: HI/LO hold new result
//  div_by_zero  out  1     one-cycle pulse with done when DIV/DIVU had b==0
//  hi           out  XLEN  HI register
//  lo           out  XLEN  LO register
// BEHAVIOUR
//  - Reset (async): state=IDLE, hi=lo=0, busy=done=div_by_zero=0, cnt=0; any
//    in-flight op discarded.
//  - States: IDLE -> RUN -> FIX -> IDLE; IDLE -> FIX direct for divide-by-zero.
//  - IDLE: priority hi_we/lo_we > start. MT write updates reg at the edge; start that
//    cycle is ignored. start=1 (no MT write): latch |a|, |b| (signed ops: two's-compl
//    magnitude, record sign_a, sign_b), cnt=0, busy=1 from next cycle.
//    DIV/DIVU with b==0 -> FIX directly.
//  - RUN: one iteration per edge, XLEN edges total (cnt 0..XLEN-1), then -> FIX.
//    MUL: 2*XLEN-bit shift-add on magnitudes. DIV: restoring, one quotient bit per edge.
//  - FIX (one edge): sign-correct and write hi/lo, assert done (and div_by_zero if
//    applicable) for the following cycle, busy drops with it, -> IDLE.
//  - Latency: start sampled at edge E0; normal op writes hi/lo at E(XLEN+1)=E33;
//    done high the cycle after E33. Divide-by-zero writes at E1.
//  - Results: MULT/MULTU {hi,lo} = full 64-bit product; MULT negates 64-bit magnitude
//    product if sign_a^sign_b. DIV: lo=quotient (neg if sign_a^sign_b),
//    hi=remainder (takes sign of dividend). DIVU unsigned.
//    INT_MIN/-1: lo=0x8000_0000, hi=0 (no trap).
//    b==0: hi=a, lo=all-ones, div_by_zero=1.
//  - busy=1: start, hi_we, lo_we ignored (stall logic must hold them).
//  - flush in RUN/FIX: -> IDLE next edge, hi/lo unchanged, no done. flush in IDLE:
//    cancels a same-cycle start; MT writes still occur.
//  - done and busy never high in the same cycle; done never back-to-back.
// TESTING
//  1. MULTU a=b=0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001; done exactly 34 cycles
//     after start cycle; busy high 33 cycles.
//  2. MULT a=-3, b=7 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFEB; DIVU 100/7 -> lo=0xE, hi=0x2.
//  3. DIV a=-7, b=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF;
//     DIV 0x8000_0000/0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
//  4. DIVU a=0x1234, b=0 -> done+div_by_zero 2 cycles after start, hi=0x1234,
//     lo=0xFFFF_FFFF.
//  5. MTLO 0xA5A5_A5A5 with start same cycle -> lo updated, start ignored;
//     start pulses while busy -> no effect, single done.
//  6. flush at RUN cycle 10 -> idle next cycle, hi/lo unchanged, no done;
//     rst mid-RUN -> hi=lo=0, busy=0 immediately.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register pair with an iterative MULT/MULTU/DIV/DIVU engine (one step per clock)
// and MTHI/MTLO write port; start/busy/done handshake towards the pipeline stall logic.
// state | meaning
// IDLE  | accepts start and MTHI/MTLO writes
// RUN   | one shift-add or restoring-divide step per edge, XLEN steps
// FIX   | sign correction, HI/LO write, done pulse on the following cycle
module hilo_muldiv_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;
    state_t state, state_nxt;

    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic [CNT_W-1:0]  cnt;
    logic              op_div, neg_lo, neg_hi, dz;
    logic              a_neg, b_neg, b_zero, launch;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, div_trial, div_diff;
    logic [XLEN-1:0]   fix_hi, fix_lo;

    assign a_neg  = op[0] & a[XLEN-1];
    assign b_neg  = op[0] & b[XLEN-1];
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;
    assign b_zero = (b == '0);
    assign launch = start & ~hi_we & ~lo_we & ~flush;
    assign busy   = (state != IDLE);

    // acc holds {partial product} for multiply, {remainder, dividend/quotient} for divide
    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    assign div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_diff  = div_trial - {1'b0, opnd};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (launch) state_nxt = (op[1] && b_zero) ? FIX : RUN;
            RUN: begin
                if (flush)                           state_nxt = IDLE;
                else if (cnt == CNT_W'(XLEN - 1))    state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fix_hi = acc[2*XLEN-1:XLEN];
        fix_lo = acc[XLEN-1:0];
        if (dz) begin
            fix_hi = acc[2*XLEN-1:XLEN];
            fix_lo = acc[XLEN-1:0];
        end else if (op_div) begin
            fix_lo = neg_lo ? -acc[XLEN-1:0] : acc[XLEN-1:0];
            fix_hi = neg_hi ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        end else if (neg_lo) begin
            {fix_hi, fix_lo} = -acc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi          <= '0;
            lo          <= '0;
            acc         <= '0;
            opnd        <= '0;
            cnt         <= '0;
            op_div      <= 1'b0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            dz          <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (launch) begin
                        cnt    <= '0;
                        op_div <= op[1];
                        neg_lo <= a_neg ^ b_neg;
                        neg_hi <= a_neg;
                        dz     <= op[1] & b_zero;
                        opnd   <= op[1] ? b_mag : a_mag;
                        if (op[1] && b_zero) acc <= {a, {XLEN{1'b1}}};
                        else                 acc <= {{XLEN{1'b0}}, op[1] ? a_mag : b_mag};
                    end
                end
                RUN: begin
                    if (!flush) begin
                        cnt <= cnt + CNT_W'(1);
                        if (op_div) begin
                            if (!div_diff[XLEN]) acc <= {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                            else                 acc <= {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
                        end else begin
                            acc <= {mul_sum, acc[XLEN-1:1]};
                        end
                    end
                end
                FIX: begin
                    if (!flush) begin
                        hi          <= fix_hi;
                        lo          <= fix_lo;
                        done        <= 1'b1;
                        div_by_zero <= dz;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Bench for hilo_muldiv_ctrl: cycle-count transaction model checked every cycle,
// directed literal cases, then randomized traffic with MT writes and flushes.
module tb_hilo_muldiv_ctrl;
    logic        clk, rst, start, flush, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_vec = 0;
    int n_err = 0;

    hilo_muldiv_ctrl #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result {div_by_zero, hi, lo} from plain arithmetic
    function automatic logic [64:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0: begin p = {32'b0, x} * {32'b0, y}; return {1'b0, p}; end
            2'd1: begin p = sx * sy; return {1'b0, p}; end
            2'd2: begin
                if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
                return {1'b0, x % y, x / y};
            end
            default: begin
                if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
                return {1'b0, 32'(sx % sy), 32'(sx / sy)};
            end
        endcase
    endfunction

    // Model: an accepted op occupies the engine for a fixed number of edges,
    // then writes its result; flush while occupied drops it.
    logic [31:0] m_hi, m_lo;
    logic        m_done, m_dz;
    logic [64:0] m_pend;
    int          m_rem;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi <= 0; m_lo <= 0; m_done <= 0; m_dz <= 0; m_rem <= 0; m_pend <= 0;
        end else begin
            m_done <= 0;
            m_dz   <= 0;
            if (m_rem != 0) begin
                if (flush) m_rem <= 0;
                else begin
                    m_rem <= m_rem - 1;
                    if (m_rem == 1) begin
                        m_hi   <= m_pend[63:32];
                        m_lo   <= m_pend[31:0];
                        m_done <= 1;
                        m_dz   <= m_pend[64];
                    end
                end
            end else begin
                if (hi_we) m_hi <= wdata;
                if (lo_we) m_lo <= wdata;
                if (start && !hi_we && !lo_we && !flush) begin
                    m_pend <= ref_op(op, a, b);
                    m_rem  <= (op[1] && b == 0) ? 1 : 33;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("busy", busy, m_rem != 0);
        check("done", done, m_done);
        check("div_by_zero", div_by_zero, m_dz);
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
    end

    task automatic idle_inputs();
        start = 0; flush = 0; hi_we = 0; lo_we = 0;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(posedge clk); #3;
        start = 1; op = o; a = x; b = y;
        @(posedge clk); #3;
        start = 0; a = $urandom; b = $urandom;
    endtask

    // Cycle index of done relative to the start cycle (0 if it never came)
    task automatic wait_done(output int lat, output int nbusy);
        lat = 0; nbusy = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin lat = i; break; end
            @(posedge clk); #3;
        end
    endtask

    task automatic mt(input logic hw, input logic lw, input logic [31:0] d);
        @(posedge clk); #3;
        hi_we = hw; lo_we = lw; wdata = d;
        @(posedge clk); #3;
        hi_we = 0; lo_we = 0;
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat, nb, ndone, first;
        rst = 1; op = 0; a = 0; b = 0; wdata = 0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #3 rst = 0;
        @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst hi", hi, 0);
        check("rst lo", lo, 0);

        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, nb);
        check("multu latency", lat, 34);
        check("multu busy cycles", nb, 33);
        check("multu hi", hi, 32'hFFFF_FFFE);
        check("multu lo", lo, 32'h0000_0001);

        issue(2'd1, 32'hFFFF_FFFD, 32'd7);
        wait_done(lat, nb);
        check("mult hi", hi, 32'hFFFF_FFFF);
        check("mult lo", lo, 32'hFFFF_FFEB);

        issue(2'd2, 32'd100, 32'd7);
        wait_done(lat, nb);
        check("divu lo", lo, 32'hE);
        check("divu hi", hi, 32'h2);

        issue(2'd3, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, nb);
        check("div lo", lo, 32'hFFFF_FFFD);
        check("div hi", hi, 32'hFFFF_FFFF);

        issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, nb);
        check("intmin lo", lo, 32'h8000_0000);
        check("intmin hi", hi, 32'h0);

        issue(2'd2, 32'h1234, 32'h0);
        wait_done(lat, nb);
        check("dz latency", lat, 2);
        check("dz flag", div_by_zero, 1);
        check("dz hi", hi, 32'h1234);
        check("dz lo", lo, 32'hFFFF_FFFF);

        @(posedge clk); #3;
        lo_we = 1; wdata = 32'hA5A5_A5A5; start = 1; op = 2'd0; a = 3; b = 3;
        @(posedge clk); #3;
        idle_inputs();
        @(negedge clk);
        check("mtlo lo", lo, 32'hA5A5_A5A5);
        check("mtlo start ignored", busy, 0);

        issue(2'd2, 32'd100, 32'd7);
        ndone = 0; first = 0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (done) begin ndone++; if (first == 0) first = i; end
            @(posedge clk); #3;
            start = (i == 3 || i == 20); op = 2'd0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
            hi_we = (i == 5); lo_we = (i == 6); wdata = 32'hDEAD_BEEF;
        end
        idle_inputs();
        check("busy-start done count", ndone, 1);
        check("busy-start latency", first, 34);
        check("busy-start hi", hi, 32'h2);
        check("busy-start lo", lo, 32'hE);

        mt(1, 0, 32'h1111_2222);
        mt(0, 1, 32'h3333_4444);
        issue(2'd0, 32'd5, 32'd5);
        repeat (9) begin @(posedge clk); #3; end
        flush = 1;
        @(posedge clk); #3;
        flush = 0;
        @(negedge clk);
        check("flush busy", busy, 0);
        ndone = 0;
        repeat (40) begin @(negedge clk); if (done) ndone++; end
        check("flush no done", ndone, 0);
        check("flush hi", hi, 32'h1111_2222);
        check("flush lo", lo, 32'h3333_4444);

        issue(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) begin @(posedge clk); #3; end
        rst = 1;
        #1;
        check("async rst busy", busy, 0);
        check("async rst hi", hi, 0);
        check("async rst lo", lo, 0);
        @(posedge clk); #3;
        rst = 0;

        repeat (6000) begin
            @(posedge clk); #3;
            start = ($urandom_range(0, 3) == 0);
            op    = 2'($urandom_range(0, 3));
            a     = rand_opnd();
            b     = rand_opnd();
            hi_we = ($urandom_range(0, 15) == 0);
            lo_we = ($urandom_range(0, 15) == 0);
            wdata = $urandom;
            flush = ($urandom_range(0, 99) == 0);
        end
        @(posedge clk); #3;
        idle_inputs();
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule
